// File: rtl/rst_seq_pkg.sv
// Shared state encodings, counter width and parameter defaults for the
// reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    REL_DDR   = 3'd3,
    REL_CORE  = 3'd4,
    PANEL     = 3'd5,
    RUN       = 3'd6,
    PWR_DN    = 3'd7
  } seq_state_e;

  localparam int unsigned CNT_W               = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYC = 1024;
  localparam int unsigned DEF_STEP_DLY        = 256;
  localparam int unsigned DEF_LOCK_TO_CYC     = 65535;

  // Number of cycles the PLL is held in reset on every pass through PLL_RST.
  localparam logic [CNT_W-1:0] PLL_RST_CYC = 16'd8;

  // Value loaded into the shared step counter when a state is entered.
  function automatic logic [CNT_W-1:0] cnt_reload(input seq_state_e       s,
                                                  input logic [CNT_W-1:0] stable_cyc,
                                                  input logic [CNT_W-1:0] step_dly);
    case (s)
      PLL_RST:           return PLL_RST_CYC;
      WAIT_LOCK, STABLE: return stable_cyc;
      default:           return step_dly;
    endcase
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Control/status bundle of the reset sequencer. The slave modport is the
// sequencer itself; the master modport is the surrounding system.
interface rst_seq_ctrl_if;

  logic       pll_lock;
  logic       restart;
  logic       clr_flag;
  logic       pll_reset_n;
  logic       ddr_rst_n;
  logic       core_rst_n;
  logic       panel_pwr_en;
  logic       bl_en;
  logic [2:0] seq_state;
  logic       seq_done;
  logic       lock_lost;
  logic       wdt_timeout;

  modport master (
    output pll_lock, restart, clr_flag,
    input  pll_reset_n, ddr_rst_n, core_rst_n, panel_pwr_en, bl_en,
           seq_state, seq_done, lock_lost, wdt_timeout
  );

  modport slave (
    input  pll_lock, restart, clr_flag,
    output pll_reset_n, ddr_rst_n, core_rst_n, panel_pwr_en, bl_en,
           seq_state, seq_done, lock_lost, wdt_timeout
  );

endinterface

// File: rtl/rst_seq_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into sysclk.
module rst_seq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the raw input through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared to "not locked" in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-up / power-down reset sequencer: holds the PLL in reset, waits for a
// stable lock, then releases DDR reset, core reset, panel power and backlight
// in timed steps, with an orderly power-down on restart.
// Optional lock watchdog enabled by defining RST_SEQ_WDT_EN.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int unsigned STEP_DLY        = DEF_STEP_DLY,
  parameter int unsigned LOCK_TO_CYC     = DEF_LOCK_TO_CYC
) (
  input  logic          sysclk,
  input  logic          sys_reset_n,
  rst_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(LOCK_STABLE_CYC);
  localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP_DLY);

  logic lock_s;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec;
  logic             pd_last_q, pd_last_d;
  logic             pll_reset_n_q, pll_reset_n_d;
  logic             ddr_rst_n_q, ddr_rst_n_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             panel_pwr_en_q, panel_pwr_en_d;
  logic             bl_en_q, bl_en_d;
  logic             seq_done_q, seq_done_d;
  logic             lock_lost_q, lock_lost_d;
  logic             enter;
  logic             lock_loss;
  logic             wdt_fire;

`ifdef RST_SEQ_WDT_EN
  localparam logic [CNT_W-1:0] LOCK_TO_C = CNT_W'(LOCK_TO_CYC);
  logic [CNT_W-1:0] wdt_q, wdt_d;
  logic             wdt_timeout_q, wdt_timeout_d;
`else
  localparam int unsigned unused_lock_to_cyc = LOCK_TO_CYC;
`endif

  rst_seq_sync u_sync (
    .clk   (sysclk),
    .rst_n (sys_reset_n),
    .d     (bus.pll_lock),
    .q     (lock_s)
  );

  // Next-state, step counter, watchdog and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pd_last_d   = pd_last_q;
    lock_lost_d = lock_lost_q;
    enter       = 1'b0;
    lock_loss   = 1'b0;
    wdt_fire    = 1'b0;
    cnt_dec     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

`ifdef RST_SEQ_WDT_EN
    wdt_d         = '0;
    wdt_timeout_d = 1'b0;
    if (state_q == WAIT_LOCK || state_q == STABLE) begin
      wdt_d = wdt_q + 1'b1;
      if (wdt_d == LOCK_TO_C) begin
        wdt_fire      = 1'b1;
        wdt_timeout_d = 1'b1;
        wdt_d         = '0;
      end
    end
`endif

    unique case (state_q)
      PLL_RST: begin
        if (cnt_dec == '0) begin
          state_d = WAIT_LOCK;
          enter   = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          enter   = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          enter   = 1'b1;
        end else if (cnt_dec == '0) begin
          state_d = REL_DDR;
          enter   = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      REL_DDR, REL_CORE, PANEL: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
        end else if (cnt_dec == '0) begin
          state_d = (state_q == REL_DDR)  ? REL_CORE :
                    (state_q == REL_CORE) ? PANEL : RUN;
          enter   = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      RUN: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
        end else if (bus.restart) begin
          state_d   = PWR_DN;
          pd_last_d = 1'b0;
          enter     = 1'b1;
        end
      end
      PWR_DN: begin
        // Two timed halves share one state code: the first ends with the
        // panel switched off, the second drops the resets.
        if (!lock_s) begin
          lock_loss = 1'b1;
        end else if (cnt_dec == '0) begin
          if (pd_last_q) begin
            state_d = PLL_RST;
            enter   = 1'b1;
          end else begin
            pd_last_d = 1'b1;
            cnt_d     = STEP_C;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
    endcase

    if (wdt_fire) begin
      state_d = PLL_RST;
      enter   = 1'b1;
    end
    if (lock_loss) begin
      state_d = WAIT_LOCK;
      enter   = 1'b1;
    end
    if (enter) begin
      cnt_d = cnt_reload(state_d, STABLE_C, STEP_C);
    end

    if (lock_loss) begin
      lock_lost_d = 1'b1;
    end else if (bus.clr_flag) begin
      lock_lost_d = 1'b0;
    end

    // Outputs follow the state being entered so they change on the same edge.
    pll_reset_n_d  = (state_d != PLL_RST);
    ddr_rst_n_d    = state_d inside {REL_DDR, REL_CORE, PANEL, RUN, PWR_DN};
    core_rst_n_d   = state_d inside {REL_CORE, PANEL, RUN, PWR_DN};
    panel_pwr_en_d = (state_d inside {PANEL, RUN}) || (state_d == PWR_DN && !pd_last_d);
    bl_en_d        = (state_d == RUN);
    seq_done_d     = (state_d == RUN);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge sysclk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q        <= PLL_RST;
      cnt_q          <= PLL_RST_CYC;
      pd_last_q      <= 1'b0;
      pll_reset_n_q  <= 1'b0;
      ddr_rst_n_q    <= 1'b0;
      core_rst_n_q   <= 1'b0;
      panel_pwr_en_q <= 1'b0;
      bl_en_q        <= 1'b0;
      seq_done_q     <= 1'b0;
      lock_lost_q    <= 1'b0;
`ifdef RST_SEQ_WDT_EN
      wdt_q          <= '0;
      wdt_timeout_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pd_last_q      <= pd_last_d;
      pll_reset_n_q  <= pll_reset_n_d;
      ddr_rst_n_q    <= ddr_rst_n_d;
      core_rst_n_q   <= core_rst_n_d;
      panel_pwr_en_q <= panel_pwr_en_d;
      bl_en_q        <= bl_en_d;
      seq_done_q     <= seq_done_d;
      lock_lost_q    <= lock_lost_d;
`ifdef RST_SEQ_WDT_EN
      wdt_q          <= wdt_d;
      wdt_timeout_q  <= wdt_timeout_d;
`endif
    end
  end

  assign bus.pll_reset_n  = pll_reset_n_q;
  assign bus.ddr_rst_n    = ddr_rst_n_q;
  assign bus.core_rst_n   = core_rst_n_q;
  assign bus.panel_pwr_en = panel_pwr_en_q;
  assign bus.bl_en        = bl_en_q;
  assign bus.seq_state    = state_q;
  assign bus.seq_done     = seq_done_q;
  assign bus.lock_lost    = lock_lost_q;
`ifdef RST_SEQ_WDT_EN
  assign bus.wdt_timeout  = wdt_timeout_q;
`else
  assign bus.wdt_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a behavioural model predicts the output
// vector after every clock edge; a monitor compares it to the DUT.
module tb_rst_seq_ctrl;

  localparam int unsigned LSC  = 16;
  localparam int unsigned STEP = 8;
  localparam int unsigned LTC  = 100;
  localparam int unsigned HOLD = 8;

  logic sysclk = 1'b0;
  logic sys_reset_n;

  rst_seq_ctrl_if bus ();

  rst_seq_ctrl #(
    .LOCK_STABLE_CYC (LSC),
    .STEP_DLY        (STEP),
    .LOCK_TO_CYC     (LTC)
  ) dut (
    .sysclk      (sysclk),
    .sys_reset_n (sys_reset_n),
    .bus         (bus)
  );

  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [10:0] exp_q[$];

  // Behavioural model: phase name (spec code), cycles spent in it, power-down half.
  int m_st, m_el, m_w;
  bit m_pd, m_s1, m_s2, m_lost, m_wdt;
  bit rl;

  function automatic logic [10:0] exp_vec();
    logic [2:0] st3;
    st3 = 3'(m_st);
    return {m_st != 0, m_st >= 3, m_st >= 4,
            (m_st == 5 || m_st == 6 || (m_st == 7 && !m_pd)),
            m_st == 6, st3, m_st == 6, m_lost, m_wdt};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bus.pll_reset_n, bus.ddr_rst_n, bus.core_rst_n, bus.panel_pwr_en,
            bus.bl_en, bus.seq_state, bus.seq_done, bus.lock_lost, bus.wdt_timeout};
  endfunction

  function automatic void model_edge(input logic r, input logic l,
                                     input logic q, input logic c);
    int nst;
    bit ls, set;
    if (!r) begin
      m_st = 0; m_el = 0; m_pd = 0; m_s1 = 0; m_s2 = 0;
      m_lost = 0; m_w = 0; m_wdt = 0;
      return;
    end
    ls    = m_s2;
    nst   = m_st;
    set   = 0;
    m_wdt = 0;
    m_el++;
    case (m_st)
      0: if (m_el == int'(HOLD)) nst = 1;
      1: if (ls) nst = 2;
      2: if (!ls) nst = 1; else if (m_el == int'(LSC)) nst = 3;
      3, 4, 5: if (!ls) set = 1; else if (m_el == int'(STEP)) nst = m_st + 1;
      6: if (!ls) set = 1; else if (q) nst = 7;
      default: begin
        if (!ls) set = 1;
        else if (m_el == int'(STEP)) begin
          if (m_pd) nst = 0;
          else begin m_pd = 1; m_el = 0; end
        end
      end
    endcase
`ifdef RST_SEQ_WDT_EN
    if (m_st == 1 || m_st == 2) begin
      m_w++;
      if (m_w == int'(LTC)) begin nst = 0; m_wdt = 1; m_w = 0; end
    end else m_w = 0;
`endif
    if (set) nst = 1;
    if (nst != m_st) begin m_el = 0; m_pd = 0; end
    if (set) m_lost = 1;
    else if (c) m_lost = 0;
    m_s2 = m_s1;
    m_s1 = l;
    m_st = nst;
  endfunction

  // One clock of stimulus; the predicted post-edge vector goes to the scoreboard.
  task automatic step(input logic r, input logic l, input logic q, input logic c);
    @(negedge sysclk);
    sys_reset_n  = r;
    bus.pll_lock = l;
    bus.restart  = q;
    bus.clr_flag = c;
    model_edge(r, l, q, c);
    exp_q.push_back(exp_vec());
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic hit_reset(input int n);
    logic [10:0] got;
    @(negedge sysclk);
    #2;
    sys_reset_n  = 1'b0;
    bus.restart  = 1'b0;
    bus.clr_flag = 1'b0;
    #1;
    got = dut_vec();
    checks++;
    if (got !== 11'b0) begin
      errors++;
      $display("FAIL async_reset t=%0t got=%b want=%b", $time, got, 11'b0);
    end
    model_edge(1'b0, bus.pll_lock, 1'b0, 1'b0);
    exp_q.push_back(exp_vec());
    for (int i = 1; i < n; i++) step(1'b0, bus.pll_lock, 1'b0, 1'b0);
  endtask

  // Monitor: compare the DUT outputs after every edge with the oldest prediction.
  initial begin
    logic [10:0] want, got;
    forever begin
      @(posedge sysclk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got  = dut_vec();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL out_vec cyc=%0d got=%b want=%b (pll,ddr,core,panel,bl,state[3],done,lost,wdt)",
                   cyc, got, want);
        end
      end
    end
  end

  initial begin
    sys_reset_n  = 1'b0;
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b0;
    bus.clr_flag = 1'b0;
    rl           = 1'b1;

    // Power-up with lock held: sequence to RUN.
    hit_reset(3);
    repeat (60) step(1, 1, 0, 0);

    // Orderly restart from RUN and back up again.
    step(1, 1, 1, 0);
    repeat (75) step(1, 1, 0, 0);

    // Lock drop in RUN, later cleared by clr_flag.
    repeat (4) step(1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    repeat (60) step(1, 1, 0, 0);

    // Restart and lock loss meet in the same RUN cycle, with clr_flag too.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (2) step(1, 1, 0, 0);

    // One-cycle lock glitch part way through STABLE.
    hit_reset(2);
    repeat (16) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (60) step(1, 1, 0, 0);

    // Lock never arrives: watchdog (when built in) or indefinite wait.
    hit_reset(2);
    repeat (130) step(1, 0, 0, 0);
    repeat (60) step(1, 1, 0, 0);

    // Randomized lock behaviour, restart, clear and reset.
    for (int i = 0; i < 2000; i++) begin
      if (rl) begin
        if ($urandom_range(0, 79) == 0) rl = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        rl = 1'b1;
      end
      if ($urandom_range(0, 599) == 0) hit_reset(1 + int'($urandom_range(0, 2)));
      else step(1, rl, $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);
    end

    @(posedge sysclk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: sysclk clocks every flop; sys_reset_n is the reset.
REQ-002 SHALL provide parameter LOCK_STABLE_CYC, default 1024: consecutive synchronized-lock cycles required before sequencing.
REQ-003 SHALL provide parameter STEP_DLY, default 256: cycles between successive release or power-down steps.
REQ-004 SHALL provide parameter LOCK_TO_CYC, default 65535: lock watchdog timeout in cycles.
REQ-005 SHALL provide port sysclk, input, 1, system clock.
REQ-006 SHALL provide port sys_reset_n, input, 1, async active-low reset.
REQ-007 SHALL provide port pll_lock, input, 1, PLL lock (asynchronous to sysclk).
REQ-008 SHALL provide port restart, input, 1, single-cycle orderly re-sequence request.
REQ-009 SHALL provide port clr_flag, input, 1, clears lock_lost.
REQ-010 SHALL provide port pll_reset_n, output, 1, PLL reset (active-low).
REQ-011 SHALL provide port ddr_rst_n, output, 1, DDR-clock-domain reset.
REQ-012 SHALL provide port core_rst_n, output, 1, core-logic reset.
REQ-013 SHALL provide port panel_pwr_en, output, 1, display panel power enable.
REQ-014 SHALL provide port bl_en, output, 1, backlight enable.
REQ-015 SHALL provide port seq_state, output, 3, current FSM state code.
REQ-016 SHALL provide port seq_done, output, 1, high only in RUN.
REQ-017 SHALL provide port lock_lost, output, 1, sticky lock-loss flag.
REQ-018 SHALL provide port wdt_timeout, output, 1, one-cycle watchdog expiry pulse.

Function
REQ-019 SHALL synchronize pll_lock through 2 flops to lock_s before any use (2-cycle latency).
REQ-020 SHALL implement the following states: PLL_RST=0, WAIT_LOCK=1, STABLE=2, REL_DDR=3, REL_CORE=4, PANEL=5, RUN=6, PWR_DN=7; all outputs registered.
REQ-021 SHALL hold pll_reset_n=0 for 8 cycles in PLL_RST, then go to WAIT_LOCK; pll_reset_n=1 in all other states.
REQ-022 SHALL move WAIT_LOCK->STABLE when lock_s=1.
REQ-023 SHALL move STABLE->REL_DDR after LOCK_STABLE_CYC consecutive lock_s=1 cycles; if lock_s=0 in STABLE, return to WAIT_LOCK and reload the count.
REQ-024 SHALL assert ddr_rst_n=1 in REL_DDR, wait STEP_DLY, go to REL_CORE.
REQ-025 SHALL assert core_rst_n=1 in REL_CORE, wait STEP_DLY, go to PANEL.
REQ-026 SHALL assert panel_pwr_en=1 in PANEL, wait STEP_DLY, go to RUN.
REQ-027 SHALL assert bl_en=1 and seq_done=1 in RUN.
REQ-028 SHALL handle lock_s=0 in REL_DDR..RUN or PWR_DN: all outputs to reset values next cycle, lock_lost set, go to WAIT_LOCK.
REQ-029 SHALL, on restart in RUN: go to PWR_DN; drop bl_en at once, panel_pwr_en after STEP_DLY, core_rst_n and ddr_rst_n after a further STEP_DLY, then go to PLL_RST.
REQ-030 SHALL ignore restart outside RUN; when restart and lock loss coincide, lock loss SHALL win.
REQ-031 SHALL use one shared 16-bit down-counter, reloaded on every state entry, with the transition taken at 0 (no wrap).
REQ-032 SHALL clear lock_lost on clr_flag; when clear and set coincide, set SHALL win.

Reset
REQ-033 SHALL, while sys_reset_n=0, force state to PLL_RST, counter to 8, pll_reset_n, ddr_rst_n, core_rst_n, panel_pwr_en, bl_en, seq_done, lock_lost and wdt_timeout to 0, and seq_state to 0.
REQ-034 SHALL restart the full sequence from PLL_RST when reset is applied in any state.

Configuration
REQ-035 SHALL, with RST_SEQ_WDT_EN defined, count a separate 16-bit timer in WAIT_LOCK+STABLE; when it reaches LOCK_TO_CYC, wdt_timeout SHALL pulse one cycle and the FSM SHALL go to PLL_RST.
REQ-036 SHALL, with RST_SEQ_WDT_EN undefined, omit the timer, tie wdt_timeout to 0 and wait for lock indefinitely.

Structure
REQ-037 SHALL place the state encodings and the parameter default constants in shared package rst_seq_pkg.
REQ-038 SHALL implement the 2-flop lock synchronizer as sub-module rst_seq_sync.

Verification (LOCK_STABLE_CYC=16, STEP_DLY=8, LOCK_TO_CYC=100)
REQ-039 SHALL cover: reset release, pll_lock held 1 -> pll_reset_n rises at cycle 8; ddr_rst_n, core_rst_n, panel_pwr_en, bl_en rise 8 cycles apart; seq_state=6.
REQ-040 SHALL cover: lock glitch low for 1 cycle at STABLE count 10 -> return to WAIT_LOCK; 16 further stable cycles are required.
REQ-041 SHALL cover: lock drop in RUN -> all enables and resets go to 0 next cycle, lock_lost=1; clr_flag clears it.
REQ-042 SHALL cover: restart pulse in RUN -> bl_en falls, panel_pwr_en falls 8 cycles later, resets fall 8 cycles after that, pll_reset_n=0 for 8 cycles.
REQ-043 SHALL cover: with RST_SEQ_WDT_EN defined and pll_lock held 0 -> wdt_timeout pulses at cycle 100 of WAIT_LOCK, then PLL_RST is re-entered; without the macro, wdt_timeout stays 0.
REQ-044 SHALL cover: restart and lock drop in the same RUN cycle -> lock-loss path taken, lock_lost=1.
